// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and datapath widths for the ALU op sequencer.
package alu_pkg;

    localparam int DATA_W = 24;
    localparam int PROD_W = 48;

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_OR      = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_SLT     = 3'b011;
    localparam logic [2:0] OP_MUL     = 3'b100;
    localparam logic [2:0] OP_XOR     = 3'b101;
    localparam logic [2:0] OP_SLL     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_MUL_LO = 2'd2,
        ST_MUL_HI = 2'd3
    } state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request handshake, result-mux and register-file write bundle of the sequencer.
interface alu_op_sequencer_if #(
    parameter int REG_AW = 4
);
    import alu_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          req_op;
    logic [REG_AW-1:0]   req_rd;
    logic [2:0]          alu_sel;
    logic [DATA_W-1:0]   alu_out;
    logic [PROD_W-1:0]   alu_mulout;
    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    // Requester / result-mux / register-file side
    modport master (
        output req_valid, req_op, req_rd, alu_out, alu_mulout,
        input  req_ready, alu_sel, rf_we, rf_waddr, rf_wdata
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op, req_rd, alu_out, alu_mulout,
        output req_ready, alu_sel, rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU request at a time into register-file writes; a MUL writes
// the low product half to rd and the high half to rd+1 on the following cycle.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus,
    output logic              busy,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  op_count
);

    state_t              state;
    state_t              state_next;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [DATA_W-1:0]   hi_q;
    logic                ready_en;
    logic                accept;
    logic                count_inc;

    // ready_en keeps req_ready low until the first edge after reset release
    assign bus.req_ready = ready_en && (state == ST_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.alu_sel   = op_q;
    assign busy          = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and register-file write outputs
    always_comb begin
        state_next   = state;
        bus.rf_we    = 1'b0;
        bus.rf_waddr = '0;
        bus.rf_wdata = '0;
        count_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.req_op == OP_MUL) begin
                        state_next = ST_MUL_LO;
                    end else if (bus.req_op != OP_ILLEGAL) begin
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = rd_q;
                bus.rf_wdata = bus.alu_out;
                count_inc    = 1'b1;
                state_next   = ST_IDLE;
            end
            ST_MUL_LO: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = rd_q;
                bus.rf_wdata = bus.alu_mulout[DATA_W-1:0];
                state_next   = ST_MUL_HI;
            end
            ST_MUL_HI: begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = rd_q + 1'b1;   // wraps to 0 from the top register
                bus.rf_wdata = hi_q;
                count_inc    = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latches, product high-half capture, error flag and op counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_AND;
            rd_q        <= '0;
            hi_q        <= '0;
            ready_en    <= 1'b0;
            err_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                op_q <= bus.req_op;
                rd_q <= bus.req_rd;
                if (bus.req_op == OP_ILLEGAL) begin
                    err_illegal <= 1'b1;
                end
            end
            if (state == ST_MUL_LO) begin
                hi_q <= bus.alu_mulout[PROD_W-1:DATA_W];
            end
            if (count_inc) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer against a transaction-level model.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        err_illegal;
    logic [15:0] op_count;
    logic        busy2;
    logic        err_illegal2;
    logic [3:0]  op_count2;

    int total;
    int bad;

    logic [15:0] model_count;
    bit          model_err;
    logic [3:0]  model_count2;

    alu_op_sequencer_if #(.REG_AW(4)) bus ();
    alu_op_sequencer_if #(.REG_AW(4)) bus2 ();

    alu_op_sequencer #(.REG_AW(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .busy        (busy),
        .err_illegal (err_illegal),
        .op_count    (op_count)
    );

    // Small-counter instance used to reach the op_count wrap quickly
    alu_op_sequencer #(.REG_AW(4), .CNT_W(4)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus2.slave),
        .busy        (busy2),
        .err_illegal (err_illegal2),
        .op_count    (op_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request at a negedge while the DUT is idle, then check each
    // write cycle against the transaction model and the idle state afterwards.
    task automatic issue(input logic [2:0] op, input logic [3:0] rd,
                         input logic [23:0] out, input logic [47:0] mul, input bit hold);
        int         guard;
        int         nwr;
        logic [3:0]  exp_a [2];
        logic [23:0] exp_d [2];
        guard = 0;
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_rd     = rd;
        bus.alu_out    = out;
        bus.alu_mulout = mul;
        while (bus.req_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 10) begin
            bad++;
            $display("FAIL accept_timeout op=%0d waited=%0d required<10", op, guard);
        end
        nwr = 0;
        exp_a[0] = rd;
        exp_d[0] = out;
        exp_a[1] = rd + 4'd1;
        exp_d[1] = mul[47:24];
        if (op == 3'b100) begin
            nwr = 2;
            exp_d[0] = mul[23:0];
        end else if (op != 3'b111) begin
            nwr = 1;
        end
        if (op == 3'b111) model_err = 1'b1;
        else              model_count = model_count + 16'd1;
        $display("txn op=%0d rd=%0d out=%06h mul=%012h hold=%0d writes=%0d", op, rd, out, mul, hold, nwr);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < nwr; i++) begin
            if (hold) begin
                bus.req_valid = 1'b1;
                bus.req_op    = 3'($urandom);
                bus.req_rd    = 4'($urandom);
            end
            total++;
            if (bus.rf_we !== 1'b1 || bus.rf_waddr !== exp_a[i] || bus.rf_wdata !== exp_d[i]) begin
                bad++;
                $display("FAIL write%0d we=%b addr=%0d data=%06h required we=1 addr=%0d data=%06h",
                         i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, exp_a[i], exp_d[i]);
            end
            total++;
            if (bus.req_ready !== 1'b0 || busy !== 1'b1 || bus.alu_sel !== op) begin
                bad++;
                $display("FAIL busy_phase ready=%b busy=%b alu_sel=%0d required ready=0 busy=1 alu_sel=%0d",
                         bus.req_ready, busy, bus.alu_sel, op);
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        total++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 4'd0 || bus.rf_wdata !== 24'd0) begin
            bad++;
            $display("FAIL idle_write we=%b addr=%0d data=%06h required 0/0/0",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata);
        end
        total++;
        if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.alu_sel !== op) begin
            bad++;
            $display("FAIL idle_state busy=%b ready=%b alu_sel=%0d required busy=0 ready=1 alu_sel=%0d",
                     busy, bus.req_ready, bus.alu_sel, op);
        end
        total++;
        if (op_count !== model_count || err_illegal !== model_err) begin
            bad++;
            $display("FAIL count_err op_count=%0d err=%b required op_count=%0d err=%b",
                     op_count, err_illegal, model_count, model_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b0 || bus.rf_we !== 1'b0 || bus.rf_waddr !== 4'd0 ||
            bus.rf_wdata !== 24'd0 || bus.alu_sel !== 3'd0 || busy !== 1'b0 ||
            err_illegal !== 1'b0 || op_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_hold ready=%b we=%b sel=%0d busy=%b err=%b cnt=%0d required all 0",
                     bus.req_ready, bus.rf_we, bus.alu_sel, busy, err_illegal, op_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready=%b busy=%b required ready=1 busy=0", bus.req_ready, busy);
        end
        model_count = 16'd0;
        model_err   = 1'b0;
    endtask

    task automatic test_add();
        issue(OP_ADD, 4'd3, 24'h000005, 48'h0, 1'b0);
    endtask

    task automatic test_mul_wrap();
        issue(OP_MUL, 4'd15, 24'h0, 48'h123456_ABCDEF, 1'b0);
    endtask

    task automatic test_illegal();
        issue(OP_ILLEGAL, 4'd6, 24'h0000AA, 48'h0, 1'b0);
        issue(OP_OR, 4'd1, 24'h00F00F, 48'h0, 1'b0);
    endtask

    task automatic test_busy_hold();
        issue(OP_MUL, 4'($urandom), 24'h0, {$urandom, $urandom}, 1'b1);
        issue(OP_XOR, 4'($urandom), 24'($urandom), 48'h0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom), 24'($urandom),
                  {$urandom, $urandom}, 1'($urandom));
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        logic [3:0]  rd;
        logic [47:0] mul;
        rd  = 4'($urandom);
        mul = {$urandom, $urandom};
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_MUL;
        bus.req_rd     = rd;
        bus.alu_mulout = mul;
        $display("txn op=4 rd=%0d mul=%012h reset_in_mul_hi", rd, mul);
        @(negedge clk);
        bus.req_valid = 1'b0;
        total++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== rd || bus.rf_wdata !== mul[23:0]) begin
            bad++;
            $display("FAIL abort_lo we=%b addr=%0d data=%06h required we=1 addr=%0d data=%06h",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, rd, mul[23:0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 4'd0 || bus.rf_wdata !== 24'd0 ||
            busy !== 1'b0 || bus.alu_sel !== 3'd0 || err_illegal !== 1'b0 ||
            op_count !== 16'd0 || bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset we=%b sel=%0d busy=%b err=%b cnt=%0d ready=%b required all 0",
                     bus.rf_we, bus.alu_sel, busy, err_illegal, op_count, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_count = 16'd0;
        model_err   = 1'b0;
        @(negedge clk);
        issue(OP_SLT, 4'd9, 24'h000001, 48'h0, 1'b0);
    endtask

    task automatic test_counter_wrap();
        logic [2:0] op;
        model_count2 = 4'd0;
        for (int n = 0; n < 20; n++) begin
            op = 3'($urandom_range(0, 6));
            bus2.req_valid  = 1'b1;
            bus2.req_op     = op;
            bus2.req_rd     = 4'($urandom);
            bus2.alu_out    = 24'($urandom);
            bus2.alu_mulout = {$urandom, $urandom};
            @(negedge clk);
            bus2.req_valid = 1'b0;
            if (op == 3'b100) @(negedge clk);
            @(negedge clk);
            model_count2 = model_count2 + 4'd1;
            $display("txn wrap n=%0d op=%0d op_count=%0d", n, op, op_count2);
            total++;
            if (op_count2 !== model_count2) begin
                bad++;
                $display("FAIL counter_wrap n=%0d op_count=%0d required %0d", n, op_count2, model_count2);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_count  = 16'd0;
        model_err    = 1'b0;
        model_count2 = 4'd0;
        rst_n = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_op      = 3'd0;
        bus.req_rd      = 4'd0;
        bus.alu_out     = 24'd0;
        bus.alu_mulout  = 48'd0;
        bus2.req_valid  = 1'b0;
        bus2.req_op     = 3'd0;
        bus2.req_rd     = 4'd0;
        bus2.alu_out    = 24'd0;
        bus2.alu_mulout = 48'd0;
        test_reset();
        test_add();
        test_mul_wrap();
        test_illegal();
        test_busy_hold();
        test_random();
        test_reset_mid_mul();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter REG_AW, default 4, SHALL set the register-file address width.
REQ-002 Parameter CNT_W, default 16, SHALL set the completed-operation counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  1  SHALL indicate a valid ALU operation request.
REQ-006 req_ready  output  1  SHALL indicate the sequencer accepts a request this cycle.
REQ-007 req_op  input  3  SHALL be the operation code: 000 AND, 001 OR, 010 ADD, 011 SLT, 100 MUL, 101 XOR, 110 SLL, 111 illegal.
REQ-008 req_rd  input  REG_AW  SHALL be the destination register.
REQ-009 alu_sel  output  3  SHALL drive the result-mux select.
REQ-010 alu_out  input  24  SHALL be the 24-bit result from the mux.
REQ-011 alu_mulout  input  48  SHALL be the 48-bit product from the mux.
REQ-012 rf_we  output  1  SHALL be the register-file write enable.
REQ-013 rf_waddr  output  REG_AW  SHALL be the register-file write address.
REQ-014 rf_wdata  output  24  SHALL be the register-file write data.
REQ-015 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-016 err_illegal  output  1  SHALL be a sticky flag for an accepted illegal opcode.
REQ-017 op_count  output  CNT_W  SHALL count completed legal operations.

Function
REQ-018 The FSM SHALL have the states IDLE, EXEC, MUL_LO and MUL_HI.
REQ-019 req_ready SHALL be 1 only in IDLE; a handshake is req_valid and req_ready on the same edge.
REQ-020 On a handshake, req_op and req_rd SHALL be latched into op_q and rd_q.
REQ-021 alu_sel SHALL equal op_q at all times and SHALL not follow req_op combinationally.
REQ-022 Handshake with op 000-011, 101 or 110: IDLE->EXEC.
REQ-023 In EXEC: rf_we=1, rf_waddr=rd_q, rf_wdata=alu_out, op_count+1, then EXEC->IDLE; the latency is one write cycle after the accept edge.
REQ-024 Handshake with op 100: IDLE->MUL_LO.
REQ-025 In MUL_LO: rf_we=1, rf_waddr=rd_q, rf_wdata=alu_mulout[23:0], alu_mulout[47:24] captured into hi_q, then MUL_LO->MUL_HI.
REQ-026 In MUL_HI: rf_we=1, rf_waddr=rd_q+1 (modulo 2^REG_AW, so a maximum rd_q wraps to 0), rf_wdata=hi_q, op_count+1, then MUL_HI->IDLE.
REQ-027 Handshake with op 111: set err_illegal, issue no write, leave op_count unchanged, remain in IDLE.
REQ-028 rf_we SHALL be 0 in IDLE; rf_waddr and rf_wdata SHALL be 0 whenever rf_we=0.
REQ-029 op_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-030 Changes on req_* while busy SHALL have no effect.
REQ-031 The maximum throughput SHALL be one non-MUL operation per 2 cycles and one MUL per 3 cycles.

Reset
REQ-032 While rst_n=0 the block SHALL hold: state=IDLE, op_q=000, rd_q=0, hi_q=0, alu_sel=000, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, err_illegal=0, op_count=0.
REQ-033 While rst_n=0, req_ready SHALL be 0; it SHALL be 1 from the first edge after deassertion.
REQ-034 Reset asserted mid-operation (EXEC, MUL_LO or MUL_HI) SHALL abort the operation immediately with no further write; a MUL aborted after MUL_LO leaves only the low half written.

Structure
REQ-035 The opcode encodings (OP_AND..OP_SLL, OP_ILLEGAL) and the state enum SHALL reside in shared package alu_pkg.
REQ-036 No sub-module is required; the FSM, latches and counter SHALL be a single module.

Verification
REQ-037 Reset, then ADD with rd=3 and alu_out=24'h00_0005: exactly one cycle with rf_we=1, waddr=3, wdata=24'h000005; op_count=1.
REQ-038 MUL with rd=15 and alu_mulout=48'h123456_ABCDEF: the write (15, 24'hABCDEF) then the write (0, 24'h123456) on consecutive cycles; op_count increments once.
REQ-039 Op 111 while op_count=2: err_illegal=1 and stays 1; no rf_we pulse; op_count stays 2.
REQ-040 req_valid held high during MUL with req_op toggling: req_ready=0 in MUL_LO and MUL_HI, alu_sel stays 100, and the next accept occurs in IDLE only.
REQ-041 rst_n pulsed low during MUL_HI: rf_we drops immediately; the state is IDLE and all outputs equal their reset values.
REQ-042 op_count preset near the limit via 65536 ops (CNT_W=16): the counter wraps to 0.
